// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS control types, widths and the saturating step helper
package dds_pkg;
  localparam int PHASE_W = 32;
  localparam logic [PHASE_W-1:0] INC_RESET_DEF = 32'd179_272;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RPT = 2'd2, LOCK = 2'd3} state_t;
  // One extra bit keeps the sum and the lower bound from wrapping
  function automatic logic [PHASE_W-1:0] sat_step(
    input logic [PHASE_W-1:0] v,
    input logic [PHASE_W-1:0] st,
    input logic [PHASE_W-1:0] lo,
    input logic [PHASE_W-1:0] hi,
    input logic up
  );
    logic [PHASE_W:0] sum, floor_lim;
    sum = {1'b0, v} + {1'b0, st};
    floor_lim = {1'b0, lo} + {1'b0, st};
    return up ? (sum > {1'b0, hi} ? hi : sum[PHASE_W-1:0])
              : ({1'b0, v} < floor_lim ? lo : v - st);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus stability counter for one active-low key
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  assign pressed = ~level;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      level <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], key_n};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dds_freq_ctrl.sv
// dds_freq_ctrl: debounced up/down keys with auto-repeat drive a saturating phase increment
module dds_freq_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 1_000_000,
  parameter logic [PHASE_W-1:0] STEP = 32'd100,
  parameter logic [PHASE_W-1:0] INC_RESET = INC_RESET_DEF,
  parameter logic [PHASE_W-1:0] INC_MIN = 32'd100,
  parameter logic [PHASE_W-1:0] INC_MAX = 32'h7FFF_FFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up_n,
  input  logic key_dn_n,
  output logic [PHASE_W-1:0] freq_inc,
  output logic inc_upd,
  output logic at_limit
);
  logic up, dn, dir_up, active, other, step, step_up;
  logic [31:0] timer;
  logic [PHASE_W-1:0] nxt;
  state_t state;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (.clk(clk), .rst_n(rst_n), .key_n(key_up_n), .pressed(up));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn (.clk(clk), .rst_n(rst_n), .key_n(key_dn_n), .pressed(dn));
  always_comb begin
    active = dir_up ? up : dn;
    other = dir_up ? dn : up;
    step = state == IDLE ? up ^ dn
         : (state == HOLD || state == RPT) && active && !other && timer == '0;
    step_up = state == IDLE ? up : dir_up;
    nxt = sat_step(freq_inc, STEP, INC_MIN, INC_MAX, step_up);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir_up <= 1'b0;
      timer <= '0;
      freq_inc <= INC_RESET;
      inc_upd <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      inc_upd <= step && nxt != freq_inc;
      if (step) begin
        freq_inc <= nxt;
        at_limit <= nxt == INC_MIN || nxt == INC_MAX;
      end
      case (state)
        IDLE:
          if (up && dn) state <= LOCK;
          else if (up || dn) begin
            state <= HOLD;
            dir_up <= up;
            timer <= 32'(REPEAT_DLY - 1);
          end
        HOLD, RPT:
          if (other) state <= LOCK;
          else if (!active) state <= IDLE;
          else if (timer == '0) begin
            state <= RPT;
            timer <= 32'(REPEAT_PER - 1);
          end else timer <= timer - 1'b1;
        default:
          if (!up && !dn) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_freq_ctrl.sv
// tb_dds_freq_ctrl: directed and random key stimulus against a cycle-level behavioural model
module tb_dds_freq_ctrl;
  localparam int DEB = 4, DLY = 20, PER = 5;
  localparam logic [31:0] STEP = 100, MIN = 100, MAX = 1000, RST = 500;
  typedef struct {int cyc; logic [31:0] val; logic lim;} exp_t;
  typedef enum {M_IDLE, M_HOLD, M_LOCK} mode_t;
  logic clk = 0, rst_n = 0, key_up_n = 1, key_dn_n = 1;
  logic [31:0] freq_inc;
  logic inc_upd, at_limit;
  int cyc = 0, tests = 0, fails = 0, pulses = 0;
  exp_t sb[$];
  logic [31:0] m_val = RST;
  logic m_lim = 0;
  dds_freq_ctrl #(.DEBOUNCE_CYC(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .STEP(STEP),
                  .INC_RESET(RST), .INC_MIN(MIN), .INC_MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .freq_inc(freq_inc), .inc_upd(inc_upd), .at_limit(at_limit));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endfunction
  task automatic apply_step(input bit go_up, input int at);
    longint r;
    r = go_up ? longint'(m_val) + STEP : longint'(m_val) - STEP;
    r = r > MAX ? MAX : r < MIN ? MIN : r;
    if (r != m_val) sb.push_back('{at, 32'(r), r == MIN || r == MAX});
    m_val = 32'(r);
    m_lim = r == MIN || r == MAX;
  endtask
  // Model: a key level flips once the last DEB synchronised samples all disagree with it
  initial begin
    bit hu[$], hd[$];
    bit lu, ld, pu, pd, dir, act, oth, flip;
    mode_t mode;
    int start, e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_val = RST; m_lim = 0; mode = M_IDLE; lu = 1; ld = 1;
        hu.delete(); hd.delete(); sb.delete();
        for (int i = 0; i < DEB + 2; i++) begin hu.push_back(1); hd.push_back(1); end
      end else begin
        pu = !lu; pd = !ld;
        case (mode)
          M_IDLE:
            if (pu && pd) mode = M_LOCK;
            else if (pu || pd) begin
              dir = pu; start = cyc + 1; mode = M_HOLD;
              apply_step(dir, cyc + 1);
            end
          M_HOLD: begin
            act = dir ? pu : pd; oth = dir ? pd : pu;
            if (oth) mode = M_LOCK;
            else if (!act) mode = M_IDLE;
            else begin
              e = cyc + 1 - start;
              if (e >= DLY && (e - DLY) % PER == 0) apply_step(dir, cyc + 1);
            end
          end
          default: if (!pu && !pd) mode = M_IDLE;
        endcase
        flip = 1;
        for (int i = 1; i <= DEB; i++) if (hu[hu.size() - 1 - i] == lu) flip = 0;
        if (flip) lu = !lu;
        flip = 1;
        for (int i = 1; i <= DEB; i++) if (hd[hd.size() - 1 - i] == ld) flip = 0;
        if (flip) ld = !ld;
        hu.push_back(key_up_n); void'(hu.pop_front());
        hd.push_back(key_dn_n); void'(hd.pop_front());
      end
    end
  end
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (inc_upd) begin
        pulses++;
        if (sb.size() == 0) chk("unexpected_pulse", freq_inc, -1);
        else begin
          x = sb.pop_front();
          chk("pulse_cycle", cyc, x.cyc);
          chk("pulse_val", freq_inc, x.val);
          chk("pulse_lim", at_limit, x.lim);
        end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        x = sb.pop_front();
        chk("missing_pulse", 0, x.val);
      end
      chk("freq_inc", freq_inc, m_val);
      chk("at_limit", at_limit, m_lim);
    end
  end
  task automatic hold(input logic u, input logic d, input int n);
    key_up_n = u; key_dn_n = d;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  initial begin
    int p0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_freq", freq_inc, 500); chk("rst_upd", inc_upd, 0); chk("rst_lim", at_limit, 0);
    @(posedge clk); #1;
    rst_n = 1;
    hold(1, 1, 1000);
    chk("idle_freq", freq_inc, 500);
    hold(0, 1, 3); hold(1, 1, 20);
    chk("glitch_freq", freq_inc, 500);
    hold(0, 1, 6);
    @(negedge clk); chk("lat_before", freq_inc, 500);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_freq", freq_inc, 600); chk("lat_upd", inc_upd, 1);
    @(posedge clk); #1;
    hold(0, 1, 2); hold(1, 1, 40);
    chk("single_step", freq_inc, 600);
    pulse_reset();
    p0 = pulses;
    hold(1, 0, 50); hold(1, 1, 30);
    chk("dn_floor", freq_inc, 100); chk("dn_lim", at_limit, 1); chk("dn_pulses", pulses - p0, 4);
    p0 = pulses;
    hold(0, 1, 70); hold(1, 1, 30);
    chk("up_ceil", freq_inc, 1000); chk("up_lim", at_limit, 1); chk("up_pulses", pulses - p0, 9);
    pulse_reset();
    hold(0, 1, 10); hold(0, 0, 15);
    chk("lock_one_step", freq_inc, 600);
    hold(0, 1, 40);
    chk("lock_hold", freq_inc, 600);
    hold(1, 1, 20); hold(0, 1, 10); hold(1, 1, 20);
    chk("unlock_step", freq_inc, 700); chk("unlock_lim", at_limit, 0);
    pulse_reset();
    hold(0, 1, 35);
    rst_n = 0;
    #1 chk("mid_rst_freq", freq_inc, 500);
    @(posedge clk); #1;
    rst_n = 1;
    hold(0, 1, 6);
    @(negedge clk); chk("rst_relatch_before", freq_inc, 500);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_relatch_step", freq_inc, 600);
    @(posedge clk); #1;
    hold(1, 1, 30);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset();
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 35));
    end
    hold(1, 1, 40);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
